// File: rtl/vector_regfile_reader.sv
// vector_regfile_reader
//   Read-side sequencer for the vector register file. A start command walks
//   count_m1+1 consecutive registers from base_addr through the file's
//   combinational read port and streams each word on a valid/ready interface.
//
//   Optional feature macro: VREG_RD_PARITY_EN
//     When it is defined, the module has an extra output out_parity = ^out_data
//     (even parity). This bit is registered together with out_data.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   start      command strobe, sampled only while idle
//   base_addr  first register to read
//   count_m1   number of words minus one
//   rd_addr    register file read address (addr_a)
//   rd_data    register file read data (vec_a), combinational
//   out_valid  out_data/out_addr/out_last hold a word
//   out_ready  consumer accepts the word when out_valid && out_ready
//   out_data   register contents
//   out_addr   register index of out_data
//   out_last   final word of the command
//   busy       sequencer is not idle
//   done       one-cycle pulse after the last word is accepted
//   out_parity (VREG_RD_PARITY_EN only) even parity of out_data
module vector_regfile_reader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count_m1,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef VREG_RD_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  // The remaining counter needs one extra bit so that it can hold the full
  // register count.
  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state, state_d;
  logic [CNT_W-1:0]  remaining, remaining_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic              out_valid_d;
  logic [DATA_W-1:0] out_data_d;
  logic [ADDR_W-1:0] out_addr_d;
  logic              out_last_d;
  logic              busy_d;
  logic              done_d;
  logic              cap_c;
  logic              last_word_c;
`ifdef VREG_RD_PARITY_EN
  logic              out_parity_d;
`endif

  // The output slot can take a new word when it is empty or is being drained
  // on this same edge.
  assign cap_c       = !out_valid || out_ready;
  assign last_word_c = (remaining == CNT_W'(1));

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    remaining_d  = remaining;
    rd_addr_d    = rd_addr;
    out_valid_d  = out_valid;
    out_data_d   = out_data;
    out_addr_d   = out_addr;
    out_last_d   = out_last;
    done_d       = 1'b0;
`ifdef VREG_RD_PARITY_EN
    out_parity_d = out_parity;
`endif

    case (state)
      S_IDLE: begin
        rd_addr_d   = '0;
        remaining_d = '0;
        if (start) begin
          rd_addr_d   = base_addr;
          remaining_d = CNT_W'(count_m1) + CNT_W'(1);
          state_d     = S_READ;
        end
      end

      S_READ: begin
        // The file's read port is combinational, so rd_data belongs to
        // rd_addr in this cycle. A write on this same edge becomes visible
        // only after the edge.
        if (cap_c) begin
          out_data_d   = rd_data;
          out_addr_d   = rd_addr;
          out_valid_d  = 1'b1;
          out_last_d   = last_word_c;
`ifdef VREG_RD_PARITY_EN
          out_parity_d = ^rd_data;
`endif
          rd_addr_d    = rd_addr + ADDR_W'(1);
          remaining_d  = remaining - CNT_W'(1);
          if (last_word_c) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          rd_addr_d   = '0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        rd_addr_d   = '0;
        remaining_d = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      remaining  <= '0;
      rd_addr    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef VREG_RD_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      remaining  <= remaining_d;
      rd_addr    <= rd_addr_d;
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
      out_addr   <= out_addr_d;
      out_last   <= out_last_d;
      busy       <= busy_d;
      done       <= done_d;
`ifdef VREG_RD_PARITY_EN
      out_parity <= out_parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_vector_regfile_reader.sv
// Testbench for vector_regfile_reader. It models the register file as an
// array and predicts each command's word stream as a queue of (addr, data).
module tb_vector_regfile_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] count_m1;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef VREG_RD_PARITY_EN
  logic          out_parity;
`endif

  logic [DW-1:0] regs [8];
  assign rd_data = regs[rd_addr];

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];

  always #5 clk = ~clk;

  vector_regfile_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count_m1  (count_m1),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
`ifdef VREG_RD_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rdaddr"}, 32'(rd_addr), 32'd0);
  endtask

  // mode 0: ready always high; mode 1: random ready; mode 2: ready low for cycles 3..5
  task automatic run_cmd(input logic [AW-1:0] base, input logic [AW-1:0] cm1,
                         input int mode, input bit inject);
    int n;
    int cyc;
    int first_valid;
    bit got_done;
    bit pending_done;
    bit stall_prev;
    bit r;
    logic [DW-1:0] p_data;
    logic [AW-1:0] p_addr;
    logic          p_last;
    n = int'(cm1) + 1;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(AW'(int'(base) + i));
      exp_data.push_back(regs[AW'(int'(base) + i)]);
    end
    @(negedge clk);
    base_addr = base;
    count_m1  = cm1;
    start     = 1'b1;
    out_ready = (mode == 0);
    cyc = 0; first_valid = -1; got_done = 0; pending_done = 0; stall_prev = 0;
    p_data = '0; p_addr = '0; p_last = 1'b0;
    while (!got_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (pending_done) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("valid_after", 32'(out_valid), 32'd0);
        got_done = 1;
      end else begin
        chk("done_early", 32'(done), 32'd0);
        chk("busy_run", 32'(busy), 32'd1);
      end
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", out_data, p_data);
        chk("stall_addr", 32'(out_addr), 32'(p_addr));
        chk("stall_last", 32'(out_last), 32'(p_last));
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      // Drive the inputs for the coming edge.
      start = inject && (cyc == 3);
      if (inject && cyc == 3) begin
        base_addr = '0;
        count_m1  = 3'd7;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 2) != 0);
        default: r = !(cyc >= 3 && cyc <= 5);
      endcase
      out_ready = r;
      if (out_valid && r && !got_done) begin
        if (exp_addr.size() == 0) begin
          chk("extra_word", 32'(out_addr), 32'hFFFF_FFFF);
        end else begin
          chk("word_addr", 32'(out_addr), 32'(exp_addr[0]));
          chk("word_data", out_data, exp_data[0]);
          chk("word_last", 32'(out_last), 32'(exp_addr.size() == 1));
`ifdef VREG_RD_PARITY_EN
          chk("word_parity", 32'(out_parity), 32'(^exp_data[0]));
`endif
          void'(exp_addr.pop_front());
          void'(exp_data.pop_front());
          if (exp_addr.size() == 0) pending_done = 1;
        end
      end
      stall_prev = out_valid && !r;
      p_data = out_data; p_addr = out_addr; p_last = out_last;
    end
    start = 1'b0;
    chk("cmd_timeout", 32'(got_done), 32'd1);
    chk("words_left", 32'(exp_addr.size()), 32'd0);
    if (mode == 0) begin
      chk("first_valid_cycle", 32'(first_valid), 32'd2);
      chk("done_cycle", 32'(cyc), 32'(n + 2));
    end
    out_ready = 1'b0;
    @(negedge clk);
    chk_idle("post_cmd");
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; base_addr = '0; count_m1 = '0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = $urandom;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset_data", out_data, 32'd0);
    chk("reset_addr", 32'(out_addr), 32'd0);
    chk("reset_last", 32'(out_last), 32'd0);
`ifdef VREG_RD_PARITY_EN
    chk("reset_parity", 32'(out_parity), 32'd0);
`endif
    rst = 1'b1;

    // Directed three-word read with known contents
    regs[3] = 32'hDEADBEEF; regs[4] = 32'h0; regs[5] = 32'hCAFEBABE;
    run_cmd(3'd3, 3'd2, 0, 1'b0);

    // Parity of single words, including odd parity
    regs[0] = 32'h00000001;
    run_cmd(3'd0, 3'd0, 0, 1'b0);
    run_cmd(3'd5, 3'd0, 0, 1'b0);

    // Address wrap
    run_cmd(3'd6, 3'd3, 0, 1'b0);

    // Backpressure in the middle of the stream
    run_cmd(3'd1, 3'd6, 2, 1'b0);

    // A start while busy is ignored
    run_cmd(3'd2, 3'd7, 0, 1'b1);

    // Reset during READ abandons the command
    @(negedge clk);
    base_addr = 3'd2; count_m1 = 3'd5; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk_idle("mid_reset");
    chk("mid_reset_data", out_data, 32'd0);
    chk("mid_reset_addr", 32'(out_addr), 32'd0);
    chk("mid_reset_last", 32'(out_last), 32'd0);
    @(negedge clk);
    chk_idle("held_reset");
    rst = 1'b1;
    out_ready = 1'b0;
    run_cmd(3'd4, 3'd4, 0, 1'b0);

    // Random commands against random contents and random ready
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 8; i++) regs[i] = $urandom;
      run_cmd(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
              (k % 3 == 0) ? 0 : 1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
